// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder_pkg: shared mode encoding and parameter sanity check
package pipelined_cla_adder_pkg;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;
  function automatic bit stages_ok(int width, int stages);
    return stages >= 1 && stages <= width && width % stages == 0;
  endfunction
endpackage

// File: rtl/pipelined_cla_adder_cla_segment.sv
// cla_segment: combinational SEG-bit carry-lookahead adder
module cla_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  logic [SEG-1:0] g, p;
  logic [SEG:0] c;
  assign g = a & b;
  assign p = a ^ b;
  // every carry is a flat sum of generate terms gated by the propagate run above them
  always_comb begin
    logic t;
    t = 1'b0;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      t = cin;
      for (int k = 0; k <= i; k++) t = t & p[k];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
  end
  assign sum = p ^ c[SEG-1:0];
  assign cout = c[SEG];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: STAGES-deep pipelined CLA adder/subtractor with valid/ready flow control
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int SEG = WIDTH / STAGES;
  if (!stages_ok(WIDTH, STAGES)) begin : g_bad
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of STAGES");
  end
  logic [WIDTH-1:0] sa   [STAGES];
  logic [WIDTH-1:0] sb   [STAGES];
  logic [WIDTH-1:0] sacc [STAGES];
  logic             sc   [STAGES];
  logic             sv   [STAGES];
  logic             ld   [STAGES+1];
  assign sa[0] = a;
  assign sb[0] = mode_e'(sub) == SUB ? ~b : b;
  assign sc[0] = sub | cin;
  assign sv[0] = in_valid;
  assign sacc[0] = '0;
  assign ld[STAGES] = out_ready;
  assign in_ready = ld[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] s;
    logic [WIDTH-1:0] nacc;
    logic co, v;
    cla_segment #(.SEG(SEG)) u_seg (
      .a(sa[k][k*SEG +: SEG]),
      .b(sb[k][k*SEG +: SEG]),
      .cin(sc[k]),
      .sum(s),
      .cout(co)
    );
    always_comb begin
      nacc = sacc[k];
      nacc[k*SEG +: SEG] = s;
    end
    always_ff @(posedge clk) v <= rst ? 1'b0 : ld[k] ? sv[k] : v;
    // a stage can take a new beat when empty or when its occupant moves on this cycle
    assign ld[k] = !v || ld[k+1];
    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] ra, rb, racc;
      logic rc;
      always_ff @(posedge clk)
        if (rst) {ra, rb, racc, rc} <= '0;
        else if (ld[k] && sv[k]) {ra, rb, racc, rc} <= {sa[k], sb[k], nacc, co};
      assign sa[k+1] = ra;
      assign sb[k+1] = rb;
      assign sacc[k+1] = racc;
      assign sc[k+1] = rc;
      assign sv[k+1] = v;
    end else begin : g_out
      always_ff @(posedge clk)
        if (rst) {sum, cout, overflow, zero} <= '0;
        else if (ld[k] && sv[k]) begin
          sum <= nacc;
          cout <= co;
          overflow <= sa[k][WIDTH-1] == sb[k][WIDTH-1] && nacc[WIDTH-1] != sa[k][WIDTH-1];
          zero <= nacc == '0;
        end
      assign out_valid = v;
    end
  end
endmodule
